reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Consumer end of the clock-divider tick.
- Takes the divider's toggling `slowclk`, resynchronises it into `clk`, and turns each rising edge into a one-cycle millisecond tick (divider configured for a 1 ms period).
- Runs the reaction-time game: random delay, light stimulus, count ms until the player reacts, flag false starts and timeouts.
- Sits between the divider/debounced buttons and the display driver.

Parameters:
- CNT_W, 14, width of `time_ms` and of the delay counter.
- MAX_MS, 9999, saturation/timeout value of `time_ms`.
- DELAY_MIN_MS, 1000, minimum stimulus delay in ticks.
- DELAY_RAND_BITS, 11, LFSR bits added to the delay; random part 0..2^DELAY_RAND_BITS-1.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- slowclk  in  1  toggling output of the clock divider; rising edge = 1 ms tick.
- start  in  1  debounced start button, level, asynchronous to clk.
- react  in  1  debounced reaction button, level, asynchronous to clk.
- led  out  1  stimulus light, high only in TIMING.
- busy  out  1  high in ARMED or TIMING.
- done  out  1  high in RESULT (valid measurement or timeout).
- false_start  out  1  high in FOUL.
- timeout  out  1  high in RESULT when reached by saturation.
- time_ms  out  CNT_W  measured reaction time in ms; held after the round ends.

Behaviour:
- Input conditioning:
  - `slowclk`, `start` and `react` each pass through a 2-flop synchroniser plus a previous-value flop.
  - Each produces a one-cycle `*_rise` pulse, 3 clk edges after the input is first sampled high.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle regardless of state; reset to LFSR_SEED.
- Reset (sync, rst=1 at a posedge): state=IDLE; led, busy, done, false_start, timeout = 0; time_ms=0; delay counter=0; LFSR=seed; sync flops=0. Reset mid-round aborts with no further outputs.
- States: IDLE, ARMED, TIMING, RESULT, FOUL. Outputs are registered, decoded from the state register plus the flags.
- IDLE, on start_rise:
  - Go to ARMED.
  - delay = DELAY_MIN_MS + LFSR[DELAY_RAND_BITS-1:0], zero-extended to CNT_W.
  - time_ms=0; timeout=0.
- ARMED:
  - Each tick_rise decrements delay.
  - A tick_rise while delay==1 (or delay==0) goes to TIMING, led=1, time_ms=0.
  - react_rise goes to FOUL, false_start=1. React wins over a simultaneous final tick.
  - start_rise is ignored.
- TIMING:
  - tick_rise increments time_ms.
  - The tick that makes time_ms==MAX_MS goes to RESULT with timeout=1; time_ms holds MAX_MS.
  - react_rise goes to RESULT with time_ms frozen. React wins over a simultaneous tick, and that tick is not counted.
  - start_rise is ignored.
- RESULT / FOUL:
  - Outputs hold.
  - start_rise goes to ARMED with a new delay and clears done, false_start, timeout, time_ms.
  - react_rise is ignored.
- Latency: `done` rises 4 clk edges after `react` is first sampled high (3 for edge detect, 1 for state update). `led` rises 4 clk edges after the qualifying `slowclk` edge.
- Arithmetic: no wrap anywhere. time_ms saturates at MAX_MS; delay never underflows below 0.
- `slowclk` held static means no ticks; the FSM waits indefinitely in ARMED/TIMING. This is legal behaviour.

Decomposition:
- Package `reaction_pkg`:
  - state enum (5 states, 3-bit encoding);
  - LFSR width and tap constants;
  - default CNT_W / MAX_MS.
- Sub-module `sync_edge`: 2-flop synchroniser plus rising-edge pulse, 1-bit. Instantiated three times (slowclk, start, react).
- FSM, counters and LFSR stay in `reaction_timer`.

Test Plan:
- Use DELAY_MIN_MS=4, DELAY_RAND_BITS=2, MAX_MS=20; bench drives slowclk directly, one rising edge every 10 clk.
- Normal round: rst, start pulse, 4..7 ticks. Required: led=1 and busy=1. Give 5 more ticks, then react. Required: done=1 exactly 4 clk after react, time_ms=5, led=0, timeout=0.
- False start: start, react after 2 ticks. Required: false_start=1, led never rises, busy=0, time_ms=0. A later start clears false_start and re-enters ARMED.
- Timeout: start, wait for led, then 20 ticks with no react. Required: done=1, timeout=1, time_ms=20. Further ticks leave time_ms at 20.
- Simultaneous events:
  - react and slowclk rise on the same clk in TIMING after 3 ticks: time_ms=3, not 4.
  - react coincident with the final delay tick in ARMED: FOUL.
- Reset mid-round: assert rst for 1 cycle during TIMING with time_ms=7. Required: next cycle all outputs 0, state IDLE. A new start works normally and the LFSR restarts from the seed, so the delay matches the first-round delay for identical start timing.

Source files
------------

// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_pkg
//  Brief    : Shared state encoding, LFSR constants and default widths for
//             the reaction-time game.
//  Revision : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    localparam int          c_LFSR_W      = 16;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] c_LFSR_TAPS   = 16'hB400;
    localparam int          c_CNT_W_DEF   = 14;
    localparam int          c_MAX_MS_DEF  = 9999;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_RESULT = 3'd3,
        ST_FOUL   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Brief    : 2-flop synchroniser with a registered one-cycle rising-edge pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer
//  Brief    : Reaction-time game driven by a 1 ms tick from the clock divider.
//  Revision : 1.0 - initial release
// ============================================================================
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int          CNT_W           = c_CNT_W_DEF,
    parameter int          MAX_MS          = c_MAX_MS_DEF,
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_RAND_BITS = 11,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowclk,
    input  logic             start,
    input  logic             react,
    output logic             led,
    output logic             busy,
    output logic             done,
    output logic             false_start,
    output logic             timeout,
    output logic [CNT_W-1:0] time_ms
);

    localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] c_MAX_M1 = CNT_W'(MAX_MS - 1);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DMIN   = CNT_W'(DELAY_MIN_MS);

    logic                w_tick_rise;
    logic                w_start_rise;
    logic                w_react_rise;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_delay;
    logic [CNT_W-1:0]    w_delay_next;
    logic [CNT_W-1:0]    r_time;
    logic [CNT_W-1:0]    w_time_next;
    logic                r_timeout;
    logic                w_timeout_next;
    logic [c_LFSR_W-1:0] r_lfsr;
    logic [CNT_W-1:0]    w_delay_load;

    sync_edge u_sync_tick (
        .clk  (clk),
        .rst  (rst),
        .din  (slowclk),
        .rise (w_tick_rise)
    );

    sync_edge u_sync_start (
        .clk  (clk),
        .rst  (rst),
        .din  (start),
        .rise (w_start_rise)
    );

    sync_edge u_sync_react (
        .clk  (clk),
        .rst  (rst),
        .din  (react),
        .rise (w_react_rise)
    );

    assign w_delay_load = c_DMIN + CNT_W'(r_lfsr[DELAY_RAND_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_delay   <= '0;
            r_time    <= '0;
            r_timeout <= 1'b0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            r_state   <= w_state_next;
            r_delay   <= w_delay_next;
            r_time    <= w_time_next;
            r_timeout <= w_timeout_next;
            r_lfsr    <= {r_lfsr[c_LFSR_W-2:0], ^(r_lfsr & c_LFSR_TAPS)};
        end
    end

    // React is checked before the tick so a coincident tick is never counted
    always_comb begin
        w_state_next   = r_state;
        w_delay_next   = r_delay;
        w_time_next    = r_time;
        w_timeout_next = r_timeout;
        case (r_state)
            ST_IDLE, ST_RESULT, ST_FOUL: begin
                if (w_start_rise) begin
                    w_state_next   = ST_ARMED;
                    w_delay_next   = w_delay_load;
                    w_time_next    = '0;
                    w_timeout_next = 1'b0;
                end
            end
            ST_ARMED: begin
                if (w_react_rise) begin
                    w_state_next = ST_FOUL;
                end else if (w_tick_rise) begin
                    w_delay_next = (r_delay != '0) ? r_delay - c_ONE : '0;
                    if (r_delay <= c_ONE) begin
                        w_state_next = ST_TIMING;
                        w_time_next  = '0;
                    end
                end
            end
            ST_TIMING: begin
                if (w_react_rise) begin
                    w_state_next = ST_RESULT;
                end else if (w_tick_rise) begin
                    if (r_time >= c_MAX_M1) begin
                        w_state_next   = ST_RESULT;
                        w_time_next    = c_MAX;
                        w_timeout_next = 1'b1;
                    end else begin
                        w_time_next = r_time + c_ONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        led         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        false_start = 1'b0;
        timeout     = 1'b0;
        time_ms     = r_time;
        case (r_state)
            ST_ARMED:  busy = 1'b1;
            ST_TIMING: begin
                busy = 1'b1;
                led  = 1'b1;
            end
            ST_RESULT: begin
                done    = 1'b1;
                timeout = r_timeout;
            end
            ST_FOUL:   false_start = 1'b1;
            default:   ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reaction_timer
//  Brief    : Directed bench with a scoreboard for round outcomes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_timer;

    localparam int CNT_W  = 14;
    localparam int MAX_MS = 20;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             slowclk = 1'b0;
    logic             start   = 1'b0;
    logic             react   = 1'b0;
    logic             led;
    logic             busy;
    logic             done;
    logic             false_start;
    logic             timeout;
    logic [CNT_W-1:0] time_ms;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic             foul;
        logic             to;
        logic [CNT_W-1:0] t;
    } exp_t;

    exp_t sb[$];
    logic prev_ev = 1'b0;

    reaction_timer #(
        .CNT_W           (CNT_W),
        .MAX_MS          (MAX_MS),
        .DELAY_MIN_MS    (4),
        .DELAY_RAND_BITS (2),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .slowclk     (slowclk),
        .start       (start),
        .react       (react),
        .led         (led),
        .busy        (busy),
        .done        (done),
        .false_start (false_start),
        .timeout     (timeout),
        .time_ms     (time_ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        slowclk = 1'b1;
        cyc(5);
        slowclk = 1'b0;
        cyc(5);
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc(4);
        start = 1'b0;
        cyc(4);
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic tick_with_react();
        slowclk = 1'b1;
        react   = 1'b1;
        cyc(5);
        slowclk = 1'b0;
        cyc(5);
    endtask

    // Monitor: each new done/false_start assertion consumes one expected outcome
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ev = 1'b0;
        end else begin
            if ((done || false_start) && !prev_ev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got outcome with time_ms=%0d, expected none", time_ms);
                end else begin
                    e = sb.pop_front();
                    check("sb_foul", false_start, e.foul);
                    check("sb_done", done, !e.foul);
                    check("sb_timeout", timeout, e.to);
                    check("sb_time", time_ms, e.t);
                end
            end
            prev_ev = done || false_start;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int d1;
        int n;
        int n2;

        // Reset state
        rst = 1'b1;
        cyc(2);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_foul", false_start, 0);
        check("rst_timeout", timeout, 0);
        check("rst_time", time_ms, 0);
        rst = 1'b0;

        // Normal round
        press_start();
        check("armed_busy", busy, 1);
        check("armed_led", led, 0);
        wait_led(d1);
        check("delay_range", (d1 >= 4 && d1 <= 7), 1);
        check("timing_led", led, 1);
        check("timing_busy", busy, 1);
        repeat (5) tick();
        check("timing_count", time_ms, 5);
        sb.push_back('{foul: 1'b0, to: 1'b0, t: 14'd5});
        react = 1'b1;
        cyc(3);
        check("done_early", done, 0);
        cyc(1);
        check("done_lat4", done, 1);
        check("result_led", led, 0);
        check("result_timeout", timeout, 0);
        check("result_time", time_ms, 5);
        check("result_busy", busy, 0);
        react = 1'b0;
        cyc(6);

        // False start
        press_start();
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        check("restart_time", time_ms, 0);
        tick();
        tick();
        check("fs_led_pre", led, 0);
        sb.push_back('{foul: 1'b1, to: 1'b0, t: 14'd0});
        react = 1'b1;
        cyc(6);
        check("fs_flag", false_start, 1);
        check("fs_busy", busy, 0);
        check("fs_led", led, 0);
        check("fs_time", time_ms, 0);
        react = 1'b0;
        cyc(6);
        tick();
        tick();
        check("fs_hold_led", led, 0);
        check("fs_hold_flag", false_start, 1);
        press_start();
        check("fs_clear", false_start, 0);
        check("fs_rearm", busy, 1);

        // Timeout
        wait_led(n);
        check("to_delay_range", (n >= 4 && n <= 7), 1);
        sb.push_back('{foul: 1'b0, to: 1'b1, t: 14'(MAX_MS)});
        repeat (19) tick();
        check("to_time19", time_ms, 19);
        check("to_done19", done, 0);
        tick();
        check("to_done", done, 1);
        check("to_flag", timeout, 1);
        check("to_time", time_ms, MAX_MS);
        repeat (2) tick();
        check("to_sat_hold", time_ms, MAX_MS);

        // React coincident with a tick in TIMING
        press_start();
        wait_led(n);
        repeat (3) tick();
        check("coinc_pre", time_ms, 3);
        sb.push_back('{foul: 1'b0, to: 1'b0, t: 14'd3});
        tick_with_react();
        check("coinc_time", time_ms, 3);
        check("coinc_done", done, 1);
        react = 1'b0;
        cyc(6);

        // Reset mid-round
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        press_start();
        wait_led(n);
        repeat (7) tick();
        check("mid_time7", time_ms, 7);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_led", led, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_foul", false_start, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_time", time_ms, 0);
        rst = 1'b0;
        press_start();
        wait_led(n2);
        check("seed_delay", n2, d1);
        check("seed_led", led, 1);

        // React coincident with the final delay tick
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        press_start();
        repeat (d1 - 1) tick();
        check("final_pre_led", led, 0);
        check("final_pre_busy", busy, 1);
        sb.push_back('{foul: 1'b1, to: 1'b0, t: 14'd0});
        tick_with_react();
        check("final_foul", false_start, 1);
        check("final_led", led, 0);
        react = 1'b0;
        cyc(6);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
